// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 encryption core.
//   state_e   : round-controller state encoding (3 bits)
//   AES_NR    : number of cipher rounds for AES-128
//   AES_KEY_W : cipher key width in bits
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Sequencer for the AES-128 encryption core. Accepts a start request carrying
// the cipher key, drives the load/advance controls of the on-the-fly key
// expansion, issues per-round enables and round-type flags to the round
// datapath, and returns a valid/ready completion handshake.
//
// Parameters
//   NR      number of cipher rounds (1..15)
//   RIDX_W  round index width, 2**RIDX_W > NR
//
// Ports
//   CLK, RST_N     clock, synchronous active-low reset
//   start_valid/start_ready, key_in   start handshake and cipher key
//   abort          synchronous cancel of the current operation
//   dp_ready       datapath can consume a round this cycle
//   key_load       registered key for the key expansion
//   key_sel        load pulse to key expansion
//   key_rd         advance pulse to key expansion
//   dp_en          datapath performs round round_idx this cycle
//   round_idx      current round number 0..NR
//   first_round    round 0 (AddRoundKey only)
//   final_round    round NR (no MixColumns)
//   busy           controller not idle
//   done_valid/done_ready              completion handshake
// -----------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int RIDX_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 abort,
  input  logic                 dp_ready,
  output logic [AES_KEY_W-1:0] key_load,
  output logic                 key_sel,
  output logic                 key_rd,
  output logic                 dp_en,
  output logic [RIDX_W-1:0]    round_idx,
  output logic                 first_round,
  output logic                 final_round,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready
);

  localparam logic [RIDX_W-1:0] LAST_RUN_IDX = RIDX_W'(NR - 1);
  localparam logic [RIDX_W-1:0] ONE_IDX      = RIDX_W'(1);

  state_e                 state_q, state_d;
  logic [RIDX_W-1:0]      round_idx_q, round_idx_d;
  logic [AES_KEY_W-1:0]   key_load_q, key_load_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    round_idx_d = round_idx_q;
    key_load_d  = key_load_q;
    start_ready = 1'b0;
    key_sel     = 1'b0;
    key_rd      = 1'b0;
    dp_en       = 1'b0;
    first_round = 1'b0;
    final_round = 1'b0;
    done_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          key_load_d = key_in;
          state_d    = ST_LOAD;
        end
      end

      // Key expansion loads round-key 0 at the end of this cycle.
      ST_LOAD: begin
        key_sel     = 1'b1;
        round_idx_d = '0;
        state_d     = ST_INIT;
      end

      // Round 0 consumes round-key 0; the same edge advances the expansion.
      ST_INIT: begin
        first_round = 1'b1;
        if (dp_ready) begin
          dp_en       = 1'b1;
          key_rd      = 1'b1;
          round_idx_d = ONE_IDX;
          state_d     = (NR == 1) ? ST_FINAL : ST_RUN;
        end
      end

      ST_RUN: begin
        if (dp_ready) begin
          dp_en       = 1'b1;
          key_rd      = 1'b1;
          round_idx_d = round_idx_q + ONE_IDX;
          if (round_idx_q == LAST_RUN_IDX) state_d = ST_FINAL;
        end
      end

      // Last round key is already present; no further advance.
      ST_FINAL: begin
        final_round = 1'b1;
        if (dp_ready) begin
          dp_en   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_d     = ST_IDLE;
          round_idx_d = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        round_idx_d = '0;
      end
    endcase

    // Abort cancels any operation and suppresses every pulse of this cycle.
    // key_load is deliberately left untouched.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      round_idx_d = '0;
      key_sel     = 1'b0;
      key_rd      = 1'b0;
      dp_en       = 1'b0;
      done_valid  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      round_idx_q <= '0;
      key_load_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      key_load_q  <= key_load_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign round_idx = round_idx_q;
  assign key_load  = key_load_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
// Bench for aes_round_ctrl. Two instances (NR=10 and NR=1) share stimulus; one
// is selected for checking at a time. A phase/round-count reference model
// predicts every output each cycle, and a behavioural AES-128 key schedule
// attached to key_sel/key_rd checks the final round key.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int RW = 4;
  localparam logic [127:0] NOM_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NOM_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start_valid, abort, dp_ready, done_ready;
  logic [127:0] key_in;

  typedef struct packed {
    logic          start_ready;
    logic [127:0]  key_load;
    logic          key_sel;
    logic          key_rd;
    logic          dp_en;
    logic [RW-1:0] round_idx;
    logic          first_round;
    logic          final_round;
    logic          busy;
    logic          done_valid;
  } obs_t;

  logic          d0_start_ready, d0_key_sel, d0_key_rd, d0_dp_en, d0_first, d0_final, d0_busy, d0_done;
  logic [127:0]  d0_key_load;
  logic [RW-1:0] d0_idx;
  logic          d1_start_ready, d1_key_sel, d1_key_rd, d1_dp_en, d1_first, d1_final, d1_busy, d1_done;
  logic [127:0]  d1_key_load;
  logic [RW-1:0] d1_idx;

  aes_round_ctrl #(.NR(10), .RIDX_W(RW)) u_dut (
    .CLK(clk), .RST_N(rst_n), .start_valid(start_valid), .start_ready(d0_start_ready),
    .key_in(key_in), .abort(abort), .dp_ready(dp_ready), .key_load(d0_key_load),
    .key_sel(d0_key_sel), .key_rd(d0_key_rd), .dp_en(d0_dp_en), .round_idx(d0_idx),
    .first_round(d0_first), .final_round(d0_final), .busy(d0_busy),
    .done_valid(d0_done), .done_ready(done_ready)
  );

  aes_round_ctrl #(.NR(1), .RIDX_W(RW)) u_dut_nr1 (
    .CLK(clk), .RST_N(rst_n), .start_valid(start_valid), .start_ready(d1_start_ready),
    .key_in(key_in), .abort(abort), .dp_ready(dp_ready), .key_load(d1_key_load),
    .key_sel(d1_key_sel), .key_rd(d1_key_rd), .dp_en(d1_dp_en), .round_idx(d1_idx),
    .first_round(d1_first), .final_round(d1_final), .busy(d1_busy),
    .done_valid(d1_done), .done_ready(done_ready)
  );

  bit   sel1;
  obs_t obs, last_obs;

  always_comb begin
    obs = '0;
    if (!sel1) begin
      obs.start_ready = d0_start_ready; obs.key_load = d0_key_load;
      obs.key_sel = d0_key_sel; obs.key_rd = d0_key_rd; obs.dp_en = d0_dp_en;
      obs.round_idx = d0_idx; obs.first_round = d0_first; obs.final_round = d0_final;
      obs.busy = d0_busy; obs.done_valid = d0_done;
    end else begin
      obs.start_ready = d1_start_ready; obs.key_load = d1_key_load;
      obs.key_sel = d1_key_sel; obs.key_rd = d1_key_rd; obs.dp_en = d1_dp_en;
      obs.round_idx = d1_idx; obs.first_round = d1_first; obs.final_round = d1_final;
      obs.busy = d1_busy; obs.done_valid = d1_done;
    end
  end

  // Reference model: phase 0 idle, 1 key load, 2 rounds, 3 result held.
  // m_k counts rounds already performed in the current operation.
  int           m_nr, m_phase, m_k;
  logic [127:0] m_key;
  int           cyc, smp_cyc;
  bit           chk_en;
  logic [127:0] rk;
  int           rcon_j;
  int           n_checks, n_fail;

  // ---------------- AES-128 key schedule (behavioural) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] r, input int j);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    for (int i = 0; i < j; i++) rc = xt(rc);
    {w0, w1, w2, w3} = r;
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] key, input int n);
    logic [127:0] r = key;
    for (int i = 0; i < n; i++) r = next_rk(r, i);
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    bit act;
    act = (m_phase == 2) && dp_ready && !abort;
    check("start_ready", 128'(obs.start_ready), 128'(m_phase == 0));
    check("busy",        128'(obs.busy),        128'(m_phase != 0));
    check("key_sel",     128'(obs.key_sel),     128'((m_phase == 1) && !abort));
    check("dp_en",       128'(obs.dp_en),       128'(act));
    check("key_rd",      128'(obs.key_rd),      128'(act && (m_k < m_nr)));
    check("first_round", 128'(obs.first_round), 128'((m_phase == 2) && (m_k == 0)));
    check("final_round", 128'(obs.final_round), 128'((m_phase == 2) && (m_k == m_nr)));
    check("done_valid",  128'(obs.done_valid),  128'((m_phase == 3) && !abort));
    check("round_idx",   128'(obs.round_idx),   128'(m_k));
    check("key_load",    obs.key_load,          m_key);
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_key = '0;
    end else if (abort && (m_phase != 0)) begin
      m_phase = 0; m_k = 0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin m_phase = 1; m_key = key_in; end
        1: m_phase = 2;
        2: if (dp_ready) begin
             if (m_k == m_nr) m_phase = 3;
             else m_k++;
           end
        default: if (done_ready) begin m_phase = 0; m_k = 0; end
      endcase
    end
  endtask

  // One clock: compare at the falling edge, advance model and the attached
  // key expansion at the rising edge, then release for new stimulus.
  task automatic cycle();
    @(negedge clk);
    if (chk_en) compare_all();
    last_obs = obs;
    smp_cyc  = cyc;
    @(posedge clk);
    model_update();
    if (last_obs.key_sel) begin
      rk = last_obs.key_load; rcon_j = 0;
    end else if (last_obs.key_rd) begin
      rk = next_rk(rk, rcon_j); rcon_j++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0; start_valid = 1'b0; abort = 1'b0; dp_ready = 1'b1; done_ready = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_n = 1'b1;
    check("rst_start_ready", 128'(last_obs.start_ready), 128'(1));
    check("rst_busy",        128'(last_obs.busy),        128'(0));
  endtask

  // One operation. stall_round/stall_len: dp_ready low for stall_len cycles
  // while round stall_round is pending. abort_round: abort when that round is
  // pending (99 = abort together with done_ready while the result is held).
  task automatic do_op(input logic [127:0] key, input int stall_round, input int stall_len,
                       input bit rnd, input int done_hold, input int abort_round,
                       input int exp_rd_on_abort);
    int  acc, dcyc, nrd, nsel, n, sc, stalls, held;
    bit  seen, aborted;
    acc = 0; dcyc = 0; nrd = 0; nsel = 0; n = 0; sc = 0; stalls = 0; held = 0;
    seen = 0; aborted = 0;
    start_valid = 1'b1; key_in = key; done_ready = 1'b0; dp_ready = 1'b1; abort = 1'b0;
    cycle();
    acc = smp_cyc;
    start_valid = 1'b0;
    key_in = ~key;
    while ((m_phase != 0) && (n < 200)) begin
      dp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ((m_phase == 2) && (m_k == stall_round) && (sc < stall_len)) begin
        dp_ready = 1'b0; sc++;
      end
      abort = (m_phase == 2) && (m_k == abort_round) && !aborted;
      done_ready = 1'b0; start_valid = 1'b0;
      if (m_phase == 3) begin
        done_ready  = (held >= done_hold);
        start_valid = !done_ready;
        held++;
        if (abort_round == 99) begin abort = 1'b1; done_ready = 1'b1; end
      end
      if (rnd && ($urandom_range(0, 63) == 0)) abort = 1'b1;
      if (abort) aborted = 1;
      if ((m_phase == 2) && !dp_ready && !abort) stalls++;
      cycle();
      n++;
      if (last_obs.key_sel) nsel++;
      if (last_obs.key_rd) nrd++;
      if (last_obs.done_valid && !seen) begin seen = 1; dcyc = smp_cyc; end
    end
    start_valid = 1'b0; done_ready = 1'b0; abort = 1'b0; dp_ready = 1'b1;
    check("op_completes_in_budget", 128'(m_phase == 0), 128'(1));
    if (!aborted) begin
      check("latency",   128'(dcyc - acc), 128'(m_nr + 3 + stalls));
      check("key_sel_n", 128'(nsel),       128'(1));
      check("key_rd_n",  128'(nrd),        128'(m_nr));
      check("final_rk",  rk,               expand(key, m_nr));
    end else if (exp_rd_on_abort >= 0) begin
      check("key_rd_n_abort", 128'(nrd), 128'(exp_rd_on_abort));
    end
    cycle();  // idle gap between operations
  endtask

  initial begin
    int n, nrd;
    logic [127:0] k;
    n_checks = 0; n_fail = 0; cyc = 0; sel1 = 1'b0; m_nr = 10;
    m_phase = 0; m_k = 0; m_key = '0; rk = '0; rcon_j = 0; key_in = '0;
    do_reset();

    // Nominal FIPS-197 key, datapath always ready.
    do_op(NOM_KEY, -1, 0, 1'b0, 0, -1, -1);
    check("nominal_rk10", rk, NOM_RK10);

    // Three stall cycles while round 5 is pending.
    do_op(NOM_KEY, 5, 3, 1'b0, 0, -1, -1);
    check("stall_rk10", rk, NOM_RK10);

    // Abort while round 4 is pending, then no advance pulses while idle.
    do_op(NOM_KEY, -1, 0, 1'b0, 0, 4, 4);
    nrd = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (last_obs.key_rd) nrd++;
    end
    check("no_rd_after_abort", 128'(nrd), 128'(0));
    do_op(128'h000102030405060708090a0b0c0d0e0f, -1, 0, 1'b0, 0, -1, -1);

    // Completion backpressure with start_valid asserted meanwhile.
    do_op(NOM_KEY, -1, 0, 1'b0, 5, -1, -1);

    // abort and done_ready together while the result is held.
    do_op(NOM_KEY, -1, 0, 1'b0, 0, 99, 10);

    // Reset while round 7 is pending.
    start_valid = 1'b1; key_in = NOM_KEY;
    cycle();
    start_valid = 1'b0;
    n = 0;
    while (!((m_phase == 2) && (m_k == 7)) && (n < 50)) begin cycle(); n++; end
    check("reach_round7", 128'((m_phase == 2) && (m_k == 7)), 128'(1));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("midrst_start_ready", 128'(last_obs.start_ready), 128'(1));
    check("midrst_round_idx",   128'(last_obs.round_idx),   128'(0));
    check("midrst_key_load",    last_obs.key_load,          128'(0));

    // Randomised operations: random keys, stalls, backpressure and aborts.
    for (int t = 0; t < 12; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      do_op(k, -1, 0, 1'b1, $urandom_range(0, 4), -1, -1);
    end

    // NR=1 instance.
    do_reset();
    sel1 = 1'b1; m_nr = 1;
    do_op(NOM_KEY, -1, 0, 1'b0, 0, -1, -1);
    check("nr1_rk1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      do_op(k, -1, 0, 1'b1, $urandom_range(0, 3), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencer for the AES-128 encryption core.
- Accepts a start request carrying the cipher key.
- Drives the load (sel) and advance (rd) controls of the on-the-fly key-expansion unit.
- Issues per-round enables and round-type flags to the round datapath (AddRoundKey / SubBytes / ShiftRows / MixColumns).
- Returns a valid/ready completion handshake.
- Sits between the top-level AES wrapper and the key-expansion plus round datapath.

Parameters:
- NR, 10, number of cipher rounds. Round-key 0 plus NR expansions. Legal range 1..15.
- RIDX_W, 4, width of the round index. Must satisfy 2^RIDX_W > NR.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous active-low reset.
- start_valid  in  1  request to encrypt with key_in.
- start_ready  out  1  controller can accept a request.
- key_in  in  128  cipher key. Sampled on the start handshake.
- abort  in  1  synchronous cancel of the current operation.
- dp_ready  in  1  round datapath can consume a round this cycle.
- key_load  out  128  registered key, presented to key expansion.
- key_sel  out  1  load pulse to key expansion (rk <= key on next edge).
- key_rd  out  1  advance pulse to key expansion (rk <= next round key on next edge).
- dp_en  out  1  datapath performs the round given by round_idx this cycle.
- round_idx  out  RIDX_W  current round number, 0..NR.
- first_round  out  1  round 0: AddRoundKey only.
- final_round  out  1  round NR: no MixColumns.
- busy  out  1  high in every state except IDLE.
- done_valid  out  1  result is ready in the datapath state register.
- done_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (RST_N low at an edge): state=IDLE, round_idx=0, key_load=0. All 1-bit outputs are 0 except start_ready=1. Reset overrides abort and all handshakes.
- States:
  - IDLE: start_ready=1. On start_valid && start_ready, capture key_in into key_load, go to LOAD.
  - LOAD: key_sel=1 for exactly one cycle, round_idx=0. Go to INIT unconditionally. Key expansion now holds round-key 0.
  - INIT: first_round=1, round_idx=0.
    - If dp_ready: dp_en=1 and key_rd=1, then round_idx<=1 and go to RUN.
    - Else hold; dp_en=0, key_rd=0.
  - RUN: round_idx 1..NR-1.
    - If dp_ready: dp_en=1, key_rd=1, round_idx increments. When round_idx==NR-1, go to FINAL.
    - Else hold with dp_en=0, key_rd=0.
    - If NR==1, INIT goes straight to FINAL.
  - FINAL: round_idx=NR, final_round=1, key_rd=0.
    - If dp_ready: dp_en=1, go to DONE.
    - Else hold.
  - DONE: done_valid=1, held until done_ready. On done_valid && done_ready, go to IDLE, round_idx<=0.
- Invariants:
  - key_rd is asserted exactly NR times per operation and only in a cycle where dp_en=1.
  - key_sel and key_rd are never high together.
  - dp_en is never high outside INIT/RUN/FINAL.
  - first_round and final_round are only high when dp_en could be high, and never high together.
- Latency: with dp_ready tied high, done_valid rises NR+3 cycles after the start handshake edge (13 for NR=10). Each dp_ready-low cycle adds one cycle.
- start_ready is 0 whenever busy=1. There is no back-to-back accept from DONE; IDLE always lasts at least one cycle.
- abort:
  - In any non-IDLE state, abort at an edge forces IDLE and round_idx=0. No key_sel, key_rd, dp_en or done_valid is issued in the abort cycle.
  - In IDLE, abort is ignored.
  - If abort and done_ready are both asserted in DONE, abort wins; the result is still dropped to IDLE, so the end state is the same.
- key_load is only written on an accepted start. It keeps its value otherwise, including after abort.
- round_idx never exceeds NR and never wraps.

Decomposition:
- Shared package aes_pkg:
  - state encoding constants ST_IDLE, ST_LOAD, ST_INIT, ST_RUN, ST_FINAL, ST_DONE (3 bits).
  - AES_NR=10, AES_KEY_W=128.
- Single module, no sub-module. The round counter is small enough to live inline with the FSM.

Test Plan:
- Nominal: key 2b7e151628aed2a6abf7158809cf4f3c, dp_ready=1.
  - key_sel high for 1 cycle, then exactly 10 key_rd pulses on rounds 0..9.
  - done_valid rises 13 cycles after accept.
  - After the final key_rd, the connected key expansion holds d014f9a8c9ee2589e13f0cc8b6630ca6.
- Stall: dp_ready low for 3 cycles during round 5.
  - round_idx holds at 5; dp_en and key_rd stay 0.
  - done_valid arrives at cycle 16.
  - Final round key matches the nominal case.
- Abort in RUN at round_idx=4: next cycle state is IDLE, start_ready=1, round_idx=0, and no further key_rd. A new start then completes normally.
- Completion backpressure: done_ready held low 5 cycles. done_valid stays high, busy=1, start_valid is ignored. Releasing done_ready gives IDLE next cycle.
- Reset mid-operation: RST_N low during round 7 gives all outputs at reset values at the next edge, including start_ready=1.
- Parameter NR=1: sequence is LOAD, INIT (key_rd), FINAL, DONE. done_valid appears 4 cycles after accept with exactly one key_rd.
